// File: rtl/psum_accum_unit_pkg.sv
// Shared definitions for the partial-sum accumulation unit.
//   state_t : controller states (IDLE, ACC, OUT)
//   sat_add : signed add clamped to the range of a 'width'-bit signed value
package psum_accum_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    // Operands arrive sign-extended to 64 bits. The 65-bit sum cannot overflow,
    // so clamping against the narrow range is exact. Callers keep the low
    // 'width' bits of the result.
    function automatic logic signed [64:0] sat_add(
        input logic signed [63:0] a,
        input logic signed [63:0] b,
        input int unsigned        width
    );
        logic signed [64:0] sum;
        logic signed [64:0] max_v;
        logic signed [64:0] min_v;
        sum   = {a[63], a} + {b[63], b};
        max_v = (65'sd1 <<< (width - 1)) - 65'sd1;
        min_v = -(65'sd1 <<< (width - 1));
        if (sum > max_v) begin
            return max_v;
        end
        if (sum < min_v) begin
            return min_v;
        end
        return sum;
    endfunction

endpackage

// File: rtl/psum_accum_unit_if.sv
// Job control and streaming handshake bundle of the accumulation unit.
//   acc_start/acc_len/relu_en : job launch (sampled together)
//   in_valid/in_ready/psum_in : input beats, COL packed signed channels
//   out_valid/out_ready/psum_out : activated result
//   busy : unit is not idle
// master = job/stream source, slave = psum_accum_unit.
interface psum_accum_unit_if #(
    parameter int COL     = 8,
    parameter int PSUM_BW = 16,
    parameter int CNT_W   = 8
);
    logic                     acc_start;
    logic [CNT_W-1:0]         acc_len;
    logic                     relu_en;
    logic                     in_valid;
    logic                     in_ready;
    logic [COL*PSUM_BW-1:0]   psum_in;
    logic                     out_valid;
    logic                     out_ready;
    logic [COL*PSUM_BW-1:0]   psum_out;
    logic                     busy;

    modport master (
        output acc_start, acc_len, relu_en, in_valid, psum_in, out_ready,
        input  in_ready, out_valid, psum_out, busy
    );

    modport slave (
        input  acc_start, acc_len, relu_en, in_valid, psum_in, out_ready,
        output in_ready, out_valid, psum_out, busy
    );
endinterface

// File: rtl/psum_accum_unit_lane.sv
// One accumulation channel: saturating signed accumulator plus optional ReLU.
//   clk, reset : clock, synchronous active-high reset
//   clr        : zero the accumulator (job start)
//   add_en     : add psum_in into the accumulator this cycle
//   relu_on    : job's latched activation mode
//   out_en     : result phase; psum_out is forced to 0 otherwise
//   psum_in    : signed input value
//   psum_out   : activated accumulator value
module psum_lane
    import psum_accum_unit_pkg::*;
#(
    parameter int PSUM_BW = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clr,
    input  logic                      add_en,
    input  logic                      relu_on,
    input  logic                      out_en,
    input  logic signed [PSUM_BW-1:0] psum_in,
    output logic        [PSUM_BW-1:0] psum_out
);
    logic signed [PSUM_BW-1:0] acc_reg;
    logic signed [PSUM_BW-1:0] acc_next;

    always_comb begin
        acc_next = acc_reg;
        if (clr) begin
            acc_next = '0;
        end else if (add_en) begin
            acc_next = PSUM_BW'(sat_add(64'(acc_reg), 64'(psum_in), PSUM_BW));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_reg <= '0;
        end else begin
            acc_reg <= acc_next;
        end
    end

    // Negative results are clamped to zero only when ReLU was latched.
    always_comb begin
        psum_out = '0;
        if (out_en && !(relu_on && acc_reg[PSUM_BW-1])) begin
            psum_out = acc_reg;
        end
    end
endmodule

// File: rtl/psum_accum_unit.sv
// Partial-sum accumulation unit: sums acc_len input beats per channel with
// saturation, then presents the (optionally ReLU-activated) result until the
// downstream accepts it.
//   clk   : clock
//   reset : synchronous active-high reset, highest priority
//   bus   : job control + in/out handshake (slave side)
module psum_accum_unit
    import psum_accum_unit_pkg::*;
#(
    parameter int COL     = 8,
    parameter int PSUM_BW = 16,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    psum_accum_unit_if.slave  bus
);
    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             relu_reg, relu_next;
    logic             clr;
    logic             add_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            relu_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            relu_reg  <= relu_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        relu_next  = relu_reg;
        clr        = 1'b0;
        add_en     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                // A zero-length job is dropped; only real jobs leave IDLE.
                if (bus.acc_start && (bus.acc_len != '0)) begin
                    state_next = ST_ACC;
                    cnt_next   = bus.acc_len;
                    relu_next  = bus.relu_en;
                    clr        = 1'b1;
                end
            end
            ST_ACC: begin
                if (bus.in_valid) begin
                    add_en   = 1'b1;
                    cnt_next = cnt_reg - 1'b1;
                    if (cnt_reg == CNT_W'(1)) begin
                        state_next = ST_OUT;
                    end
                end
            end
            ST_OUT: begin
                if (bus.out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign bus.in_ready  = (state_reg == ST_ACC);
    assign bus.out_valid = (state_reg == ST_OUT);
    assign bus.busy      = (state_reg != ST_IDLE);

    generate
        for (genvar gi = 0; gi < COL; gi++) begin : g_lane
            psum_lane #(
                .PSUM_BW (PSUM_BW)
            ) u_lane (
                .clk      (clk),
                .reset    (reset),
                .clr      (clr),
                .add_en   (add_en),
                .relu_on  (relu_reg),
                .out_en   (state_reg == ST_OUT),
                .psum_in  (bus.psum_in[gi*PSUM_BW +: PSUM_BW]),
                .psum_out (bus.psum_out[gi*PSUM_BW +: PSUM_BW])
            );
        end
    endgenerate
endmodule

// File: tb/tb_psum_accum_unit.sv
// Randomized self-checking bench for psum_accum_unit with an arithmetic
// reference model of the per-channel saturating sum and activation.
module tb_psum_accum_unit;
    localparam int COL     = 8;
    localparam int PSUM_BW = 16;
    localparam int CNT_W   = 8;
    localparam int W       = COL * PSUM_BW;
    localparam longint SMAX = (64'sd1 <<< (PSUM_BW - 1)) - 1;
    localparam longint SMIN = -(64'sd1 <<< (PSUM_BW - 1));

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    psum_accum_unit_if #(.COL(COL), .PSUM_BW(PSUM_BW), .CNT_W(CNT_W)) bus ();

    psum_accum_unit #(.COL(COL), .PSUM_BW(PSUM_BW), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int job_id = 0;
    logic [W-1:0] beats_q[$];

    task automatic check_val(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer sum per channel, clamped after every add.
    function automatic logic [W-1:0] model(input logic relu);
        logic [W-1:0] r;
        logic [PSUM_BW-1:0] raw;
        longint acc;
        r = '0;
        for (int k = 0; k < COL; k++) begin
            acc = 0;
            foreach (beats_q[b]) begin
                raw = beats_q[b][k*PSUM_BW +: PSUM_BW];
                acc = acc + longint'($signed(raw));
                if (acc > SMAX) acc = SMAX;
                if (acc < SMIN) acc = SMIN;
            end
            if (relu && acc < 0) acc = 0;
            r[k*PSUM_BW +: PSUM_BW] = PSUM_BW'(acc);
        end
        return r;
    endfunction

    function automatic logic [PSUM_BW-1:0] rand_ch();
        int sel;
        sel = $urandom_range(3);
        case (sel)
            0: return PSUM_BW'($urandom_range(40) - 20);
            1: return PSUM_BW'($urandom);
            2: return PSUM_BW'(SMAX - $urandom_range(100));
            default: return PSUM_BW'(SMIN + $urandom_range(100));
        endcase
    endfunction

    function automatic logic [W-1:0] rand_vec();
        logic [W-1:0] v;
        for (int k = 0; k < COL; k++) v[k*PSUM_BW +: PSUM_BW] = rand_ch();
        return v;
    endfunction

    function automatic logic [W-1:0] mk2(input int c0, input int c1);
        logic [W-1:0] v;
        v = '0;
        v[0 +: PSUM_BW]       = PSUM_BW'(c0);
        v[PSUM_BW +: PSUM_BW] = PSUM_BW'(c1);
        return v;
    endfunction

    // Runs the job described by beats_q from IDLE through the output handshake.
    task automatic run_job(input string name, input bit relu, input int gap_pct,
                           input int hold, input bit inject);
        int len;
        logic [W-1:0] exp;
        len = beats_q.size();
        exp = model(relu);
        bus.acc_start = 1'b1;
        bus.acc_len   = CNT_W'(len);
        bus.relu_en   = relu;
        tick();
        bus.acc_start = 1'b0;
        bus.relu_en   = 1'($urandom);
        check_val({name, "_busy"}, W'(bus.busy), W'(1));
        check_val({name, "_in_ready"}, W'(bus.in_ready), W'(1));
        for (int b = 0; b < len; b++) begin
            for (int g = 0; g < 3 && $urandom_range(99) < gap_pct; g++) begin
                bus.in_valid  = 1'b0;
                bus.psum_in   = rand_vec();
                bus.out_ready = 1'($urandom);
                tick();
                check_val({name, "_gap_ov"}, W'(bus.out_valid), W'(0));
                check_val({name, "_gap_out"}, bus.psum_out, '0);
            end
            bus.in_valid  = 1'b1;
            bus.psum_in   = beats_q[b];
            bus.out_ready = 1'($urandom);
            if (inject && b == 0) begin
                bus.acc_start = 1'b1;
                bus.acc_len   = CNT_W'($urandom_range(200, 1));
                bus.relu_en   = ~relu;
            end
            tick();
            bus.acc_start = 1'b0;
            if (b < len - 1) begin
                check_val({name, "_acc_ov"}, W'(bus.out_valid), W'(0));
                check_val({name, "_acc_rdy"}, W'(bus.in_ready), W'(1));
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check_val({name, "_lat_ov"}, W'(bus.out_valid), W'(1));
        check_val({name, "_result"}, bus.psum_out, exp);
        for (int h = 0; h < hold; h++) begin
            bus.psum_in = rand_vec();
            tick();
            check_val({name, "_hold_ov"}, W'(bus.out_valid), W'(1));
            check_val({name, "_hold_out"}, bus.psum_out, exp);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check_val({name, "_done_busy"}, W'(bus.busy), W'(0));
        check_val({name, "_done_ov"}, W'(bus.out_valid), W'(0));
        check_val({name, "_done_out"}, bus.psum_out, '0);
        $display("job %0d %s len=%0d relu=%0d result=%h", job_id, name, len, relu, exp);
        job_id++;
    endtask

    initial begin
        logic [W-1:0] exp_v;
        reset         = 1'b1;
        bus.acc_start = 1'b0;
        bus.acc_len   = '0;
        bus.relu_en   = 1'b0;
        bus.in_valid  = 1'b0;
        bus.psum_in   = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        check_val("rst_busy", W'(bus.busy), W'(0));
        check_val("rst_in_ready", W'(bus.in_ready), W'(0));
        check_val("rst_out_valid", W'(bus.out_valid), W'(0));
        check_val("rst_psum_out", bus.psum_out, '0);
        reset = 1'b0;
        tick();

        // Directed: relu on and off.
        beats_q = {mk2(5, -10), mk2(-2, 3), mk2(4, 2)};
        exp_v = mk2(7, 0);
        check_val("model_relu", model(1'b1), exp_v);
        run_job("relu_on", 1'b1, 0, 0, 1'b0);
        exp_v = mk2(7, -5);
        check_val("model_pass", model(1'b0), exp_v);
        run_job("relu_off", 1'b0, 0, 0, 1'b0);

        // Saturation both ways.
        beats_q = {mk2(30000, 0), mk2(10000, 0)};
        run_job("sat_pos", 1'b0, 0, 0, 1'b0);
        beats_q = {mk2(-30000, 0), mk2(-10000, 0)};
        run_job("sat_neg", 1'b0, 0, 0, 1'b0);

        // Input gaps and a 4-cycle held output.
        beats_q = {rand_vec(), rand_vec(), rand_vec()};
        run_job("gaps_hold", 1'b0, 70, 4, 1'b0);

        // Zero-length start is ignored.
        bus.acc_start = 1'b1;
        bus.acc_len   = '0;
        tick();
        bus.acc_start = 1'b0;
        check_val("zero_len_busy", W'(bus.busy), W'(0));
        check_val("zero_len_ov", W'(bus.out_valid), W'(0));
        tick();
        check_val("zero_len_ov2", W'(bus.out_valid), W'(0));

        // acc_start during ACC leaves the job untouched.
        beats_q = {rand_vec(), rand_vec(), rand_vec(), rand_vec()};
        run_job("start_in_acc", 1'b1, 30, 1, 1'b1);

        // Reset mid-job with competing inputs.
        bus.acc_start = 1'b1;
        bus.acc_len   = CNT_W'(4);
        bus.relu_en   = 1'b0;
        tick();
        bus.acc_start = 1'b0;
        for (int b = 0; b < 2; b++) begin
            bus.in_valid = 1'b1;
            bus.psum_in  = rand_vec();
            tick();
        end
        reset         = 1'b1;
        bus.acc_start = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        reset         = 1'b0;
        bus.acc_start = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check_val("abort_busy", W'(bus.busy), W'(0));
        check_val("abort_ov", W'(bus.out_valid), W'(0));
        check_val("abort_in_ready", W'(bus.in_ready), W'(0));
        check_val("abort_out", bus.psum_out, '0);
        tick();
        check_val("abort_ov2", W'(bus.out_valid), W'(0));
        beats_q = {mk2(9, 0)};
        run_job("after_abort", 1'b0, 0, 0, 1'b0);

        // Randomized jobs.
        for (int j = 0; j < 40; j++) begin
            int len;
            beats_q = {};
            len = $urandom_range(12, 1);
            for (int b = 0; b < len; b++) beats_q.push_back(rand_vec());
            run_job("rand", 1'($urandom), $urandom_range(50), $urandom_range(3),
                    1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
